mem_frame_writer: RTL and testbench

//  Write-channel master for one mem_ctrl chN_wr_burst_* port. Buffers an input word stream
//  in an internal FIFO and issues write bursts of up to BURST_LEN words at consecutive

---
 rtl/mem_frame_writer.sv | 201 ++++++++++++++++++++
 tb/tb_mem_frame_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_frame_writer.sv
// mem_frame_writer: FIFO-buffered write-burst master for one mem_ctrl write channel.
// Optional build macro MEM_WR_AUTO_WRAP_EN reloads the frame on completion (ring-buffer capture).
module mem_frame_writer #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 27,
  parameter int BURST_LEN     = 64,
  parameter int FIFO_AW       = 9
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic [ADDR_BITS-1:0]     base_addr,
  input  logic [ADDR_BITS-1:0]     frame_len,
  input  logic                     in_valid,
  input  logic [MEM_DATA_BITS-1:0] in_data,
  output logic                     in_ready,
  output logic                     overflow,
  output logic                     frame_done,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish
);
  localparam int CW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [MEM_DATA_BITS-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q;
  logic [MEM_DATA_BITS-1:0] data_q;
  logic                     full_s, empty_s, push_s, pop_s;

  logic [0:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] left_q, left_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [ADDR_BITS-1:0] flen_q, flen_d;
  logic [ADDR_BITS-1:0] baddr_q, baddr_d;
  logic [9:0]           blen_q, blen_d;
  logic                 pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [9:0]           cur_len_s;
  logic [ADDR_BITS-1:0] left_after_s;
  logic                 go_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});
  assign push_s  = in_valid && !full_s;
  // An empty-FIFO data request is illegal upstream; it must not corrupt the pointers.
  assign pop_s   = wr_burst_data_req && !empty_s;

  // FIFO storage array; contents are only observable after being pushed
  always_ff @(posedge mem_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers, occupancy and the registered read word
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {FIFO_AW{1'b0}};
      rd_ptr_q <= {FIFO_AW{1'b0}};
      count_q  <= {CW{1'b0}};
      data_q   <= {MEM_DATA_BITS{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_q   <= mem_q[rd_ptr_q];
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Burst sizing: a full burst, or the remainder of the frame
  always_comb begin
    if (left_q >= ADDR_BITS'(BURST_LEN)) begin
      cur_len_s = 10'(BURST_LEN);
    end else begin
      cur_len_s = left_q[9:0];
    end
    go_s         = (left_q != {ADDR_BITS{1'b0}}) && (32'(count_q) >= 32'(cur_len_s));
    left_after_s = left_q - ADDR_BITS'(blen_q);
  end

  // Burst FSM next-state and frame bookkeeping
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    pend_d  = pend_q;
    blen_d  = blen_q;
    baddr_d = baddr_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | (in_valid & full_s);
    if (frame_start) begin
      base_d = base_addr;
      flen_d = frame_len;
    end else begin
      base_d = base_q;
      flen_d = flen_q;
    end
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          addr_d = base_addr;
          left_d = frame_len;
          ovf_d  = 1'b0;
          pend_d = 1'b0;
        end else if (pend_q) begin
          addr_d = base_q;
          left_d = flen_q;
          ovf_d  = 1'b0;
          pend_d = 1'b0;
        end else if (go_s) begin
          state_d = S_REQ;
          blen_d  = cur_len_s;
          baddr_d = addr_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (frame_start) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (wr_burst_finish) begin
          state_d = S_IDLE;
          addr_d  = addr_q + ADDR_BITS'(blen_q);
          left_d  = left_after_s;
          if (left_after_s == {ADDR_BITS{1'b0}}) begin
            done_d = 1'b1;
`ifdef MEM_WR_AUTO_WRAP_EN
            addr_d = base_d;
            left_d = flen_d;
`endif
          end else begin
            done_d = 1'b0;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Burst FSM and frame state registers
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_BITS{1'b0}};
      left_q  <= {ADDR_BITS{1'b0}};
      base_q  <= {ADDR_BITS{1'b0}};
      flen_q  <= {ADDR_BITS{1'b0}};
      baddr_q <= {ADDR_BITS{1'b0}};
      blen_q  <= 10'd0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      base_q  <= base_d;
      flen_q  <= flen_d;
      baddr_q <= baddr_d;
      blen_q  <= blen_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign in_ready      = !full_s;
  assign overflow      = ovf_q;
  assign frame_done    = done_q;
  assign wr_burst_req  = (state_q == S_REQ);
  assign wr_burst_len  = blen_q;
  assign wr_burst_addr = baddr_q;
  assign wr_burst_data = data_q;

endmodule

// File: tb/tb_mem_frame_writer.sv
// Directed self-checking bench for mem_frame_writer with a simple arbiter model.
// Honours MEM_WR_AUTO_WRAP_EN for the ring-buffer scenario.
module tb_mem_frame_writer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [26:0] base_addr;
  logic [26:0] frame_len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        overflow;
  logic        frame_done;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [26:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic [31:0] wr_burst_data;
  logic        wr_burst_finish;

  int tests = 0;
  int fails = 0;

  mem_frame_writer dut (
    .mem_clk          (clk),
    .rst_n            (rst_n),
    .frame_start      (frame_start),
    .base_addr        (base_addr),
    .frame_len        (frame_len),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .overflow         (overflow),
    .frame_done       (frame_done),
    .wr_burst_req     (wr_burst_req),
    .wr_burst_len     (wr_burst_len),
    .wr_burst_addr    (wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_data    (wr_burst_data),
    .wr_burst_finish  (wr_burst_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pat(input int k);
    return 32'hD000_0000 + 32'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [26:0] b, input logic [26:0] l);
    frame_start = 1'b1;
    base_addr   = b;
    frame_len   = l;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pat(first + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (wr_burst_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 64'(wr_burst_req), 64'd1);
  endtask

  // Arbiter model: check the request, pull exp_len words back-to-back, then finish.
  task automatic serve_burst(input string tag, input logic [26:0] exp_addr, input int exp_len,
                             input int first, input logic exp_done);
    wait_req(tag);
    chk({tag, "_addr"}, 64'(wr_burst_addr), 64'(exp_addr));
    chk({tag, "_len"}, 64'(wr_burst_len), 64'(exp_len));
    for (int i = 0; i < exp_len; i++) begin
      wr_burst_data_req = 1'b1;
      @(negedge clk);
      chk($sformatf("%s_data%0d", tag, i), 64'(wr_burst_data), 64'(pat(first + i)));
    end
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b1;
    @(negedge clk);
    wr_burst_finish = 1'b0;
    chk({tag, "_done"}, 64'(frame_done), 64'(exp_done));
    chk({tag, "_req_drop"}, 64'(wr_burst_req), 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    rst_n             = 1'b0;
    frame_start       = 1'b0;
    base_addr         = 27'd0;
    frame_len         = 27'd0;
    in_valid          = 1'b0;
    in_data           = 32'd0;
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_req", 64'(wr_burst_req), 64'd0);
    chk("rst_len", 64'(wr_burst_len), 64'd0);
    chk("rst_addr", 64'(wr_burst_addr), 64'd0);
    chk("rst_data", 64'(wr_burst_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: two full bursts
    start_frame(27'h100, 27'd128);
    push_words(0, 128);
    serve_burst("t1b0", 27'h100, 64, 0, 1'b0);
    serve_burst("t1b1", 27'h140, 64, 64, 1'b1);
    repeat (5) @(negedge clk);
    chk("t1_idle_after_frame", 64'(wr_burst_req), 64'd0);

    // T2: shortened final burst, no request until enough words are buffered
    start_frame(27'h300, 27'd100);
    push_words(1000, 63);
    repeat (3) @(negedge clk);
    chk("t2_no_req_63", 64'(wr_burst_req), 64'd0);
    push_words(1063, 1);
    serve_burst("t2b0", 27'h300, 64, 1000, 1'b0);
    push_words(1064, 35);
    repeat (4) @(negedge clk);
    chk("t2_no_req_35", 64'(wr_burst_req), 64'd0);
    push_words(1099, 1);
    serve_burst("t2b1", 27'h340, 36, 1064, 1'b1);

    // T4: frame_start during a burst is deferred until the burst finishes
    start_frame(27'h1000, 27'd128);
    push_words(2000, 128);
    wait_req("t4_pre");
    start_frame(27'h2000, 27'd64);
    chk("t4_req_held", 64'(wr_burst_req), 64'd1);
    serve_burst("t4b0", 27'h1000, 64, 2000, 1'b0);
    serve_burst("t4b1", 27'h2000, 64, 2064, 1'b1);

    // T5: asynchronous reset while requesting
    start_frame(27'h500, 27'd64);
    push_words(4000, 513);
    chk("t5_overflow_set", 64'(overflow), 64'd1);
    chk("t5_full", 64'(in_ready), 64'd0);
    chk("t5_req_up", 64'(wr_burst_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_req_drop", 64'(wr_burst_req), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_overflow_clr", 64'(overflow), 64'd0);
    chk("t5_no_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_no_done_later", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T3: overflow on full FIFO, retained contents, clear on frame_start
    for (int i = 0; i < 520; i++) begin
      if (i == 511) chk("t3_ready_511", 64'(in_ready), 64'd1);
      if (i == 512) chk("t3_ready_512", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      in_data  = pat(3000 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_no_req", 64'(wr_burst_req), 64'd0);
    start_frame(27'h4000, 27'd512);
    chk("t3_overflow_clr", 64'(overflow), 64'd0);
    for (int b = 0; b < 8; b++) begin
      serve_burst($sformatf("t3b%0d", b), 27'h4000 + 27'(64 * b), 64, 3000 + 64 * b, (b == 7));
    end
    chk("t3_ready_after", 64'(in_ready), 64'd1);

`ifdef MEM_WR_AUTO_WRAP_EN
    // T6: automatic frame reload, every burst at base
    start_frame(27'h600, 27'd64);
    push_words(5000, 192);
    for (int b = 0; b < 3; b++) begin
      serve_burst($sformatf("t6b%0d", b), 27'h600, 64, 5000 + 64 * b, 1'b1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
